branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 114 +++++++++++
 tb/tb_branch_predict_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with saturating direction counters
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        flush_btb,
    output logic        modify_pc,
    output logic [31:0] update_pc,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic [31:0]      r_br_count;
    logic [31:0]      r_mp_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_res;
    logic             w_act;
    logic             w_mispredict;
    logic [CNT_W-1:0] w_cnt_upd;

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[31:IDX_W+2];
    assign pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = pred_hit && r_cnt[w_if_idx][CNT_W-1];
    assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + 32'd4;

    assign w_ex_idx     = ex_pc[IDX_W+1:2];
    assign w_ex_tag     = ex_pc[31:IDX_W+2];
    assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_res        = ex_valid && (ex_is_branch || ex_is_jump);
    assign w_act        = ex_is_jump || ex_taken;
    assign w_mispredict = w_res && ((w_act != ex_pred_taken) ||
                                    (w_act && (ex_pred_target != ex_target)));

    assign modify_pc = w_mispredict;
    assign update_pc = w_act ? ex_target : ex_pc + 32'd4;
    assign br_count  = r_br_count;
    assign mp_count  = r_mp_count;

    always_comb begin
        w_cnt_upd = r_cnt[w_ex_idx];
        if (ex_is_jump) begin
            w_cnt_upd = CNT_MAX;
        end else if (w_act) begin
            if (r_cnt[w_ex_idx] != CNT_MAX) w_cnt_upd = r_cnt[w_ex_idx] + CNT_W'(1);
        end else begin
            if (r_cnt[w_ex_idx] != '0) w_cnt_upd = r_cnt[w_ex_idx] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else if (flush_btb) begin
            for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
        end else if (w_res) begin
            if (w_ex_hit) begin
                r_cnt[w_ex_idx] <= w_cnt_upd;
                if (w_act) r_target[w_ex_idx] <= ex_target;
            end else if (w_act) begin
                // Allocation evicts whatever aliases into this slot.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_cnt[w_ex_idx]    <= ex_is_jump ? CNT_MAX : CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            if (w_res && (r_br_count != '1)) r_br_count <= r_br_count + 32'd1;
            if (w_mispredict && (r_mp_count != '1)) r_mp_count <= r_mp_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        flush_btb;
    logic        modify_pc;
    logic [31:0] update_pc;
    logic [31:0] br_count;
    logic [31:0] mp_count;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int S_HIT = 0, S_TKN = 1, S_TGT = 2, S_MOD = 3, S_UPD = 4, S_BR = 5, S_MP = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    branch_predict_unit #(.ENTRIES(16), .CNT_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush_btb      (flush_btb),
        .modify_pc      (modify_pc),
        .update_pc      (update_pc),
        .br_count       (br_count),
        .mp_count       (mp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_of(input int sel);
        case (sel)
            S_HIT:   return {31'd0, pred_hit};
            S_TKN:   return {31'd0, pred_taken};
            S_TGT:   return pred_target;
            S_MOD:   return {31'd0, modify_pc};
            S_UPD:   return update_pc;
            S_BR:    return br_count;
            default: return mp_count;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, obs_of(e.sel), e.exp);
        end
    endtask

    task automatic drive(input logic b, input logic j, input logic [31:0] pc, input logic t,
                         input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
        ex_valid       = 1'b1;
        ex_is_branch   = b;
        ex_is_jump     = j;
        ex_pc          = pc;
        ex_taken       = t;
        ex_target      = tg;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    // Advance one edge, drop the resolve, and settle before sampling.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        ex_valid  = 1'b0;
        flush_btb = 1'b0;
        #1;
    endtask

    task automatic expect_pred(input string tag, input logic [31:0] pc, input logic hit,
                               input logic tkn, input logic [31:0] tgt);
        if_pc = pc;
        #1;
        push({tag, "_hit"}, S_HIT, {31'd0, hit});
        push({tag, "_taken"}, S_TKN, {31'd0, tkn});
        push({tag, "_target"}, S_TGT, tgt);
        drain();
    endtask

    logic        tb_t   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        tb_pt  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        tb_tk  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_br;
    logic [31:0] exp_mp;
    logic        exp_mod;

    initial begin
        rst_n = 1'b0; if_pc = 32'h100; flush_btb = 1'b0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_pc = '0;
        ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        #2;
        push("rst_hit", S_HIT, 32'd0);
        push("rst_taken", S_TKN, 32'd0);
        push("rst_target", S_TGT, 32'h104);
        push("rst_br", S_BR, 32'd0);
        push("rst_mp", S_MP, 32'd0);
        push("rst_modify", S_MOD, 32'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss allocates weakly-taken.
        @(negedge clk);
        drive(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
        #1;
        push("alloc_modify", S_MOD, 32'd1);
        push("alloc_update", S_UPD, 32'h200);
        push("alloc_nobypass", S_HIT, 32'd0);
        drain();
        cyc();
        push("alloc_br", S_BR, 32'd1);
        push("alloc_mp", S_MP, 32'd1);
        drain();
        expect_pred("alloc", 32'h100, 1, 1, 32'h200);

        // Train to 3, then walk down past zero and back up once.
        exp_br = 32'd1;
        exp_mp = 32'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1, 0, 32'h100, tb_t[i], 32'h200, tb_pt[i], 32'h200);
            exp_mod = (tb_t[i] != tb_pt[i]);
            #1;
            push($sformatf("train%0d_modify", i), S_MOD, {31'd0, exp_mod});
            push($sformatf("train%0d_update", i), S_UPD, tb_t[i] ? 32'h200 : 32'h104);
            drain();
            cyc();
            exp_br = exp_br + 1;
            exp_mp = exp_mp + {31'd0, exp_mod};
            push($sformatf("train%0d_br", i), S_BR, exp_br);
            push($sformatf("train%0d_mp", i), S_MP, exp_mp);
            drain();
            expect_pred($sformatf("train%0d", i), 32'h100, 1, tb_tk[i],
                        tb_tk[i] ? 32'h200 : 32'h104);
        end

        // JALR aliasing to the same slot evicts; ex_taken is ignored for jumps.
        @(negedge clk);
        drive(0, 1, 32'h140, 0, 32'h300, 0, 32'h0);
        #1;
        push("jalr_modify", S_MOD, 32'd1);
        push("jalr_update", S_UPD, 32'h300);
        drain();
        cyc();
        expect_pred("evicted", 32'h100, 0, 0, 32'h104);
        expect_pred("jalr", 32'h140, 1, 1, 32'h300);

        @(negedge clk);
        drive(0, 1, 32'h140, 1, 32'h300, 1, 32'h2FC);
        #1;
        push("tgtmis_modify", S_MOD, 32'd1);
        push("tgtmis_update", S_UPD, 32'h300);
        drain();
        cyc();
        push("tgtmis_br", S_BR, 32'd9);
        push("tgtmis_mp", S_MP, 32'd6);
        drain();

        // Non-control instruction is not a resolve.
        @(negedge clk);
        drive(0, 0, 32'h140, 1, 32'h500, 0, 32'h0);
        #1;
        push("nonbr_modify", S_MOD, 32'd0);
        drain();
        cyc();
        push("nonbr_br", S_BR, 32'd9);
        drain();

        // Not-taken miss leaves the aliased occupant intact.
        @(negedge clk);
        drive(1, 0, 32'h180, 0, 32'h900, 0, 32'h0);
        #1;
        push("ntmiss_modify", S_MOD, 32'd0);
        push("ntmiss_update", S_UPD, 32'h184);
        drain();
        cyc();
        expect_pred("ntmiss_keep", 32'h140, 1, 1, 32'h300);

        // Same-cycle lookup sees old target.
        @(negedge clk);
        if_pc = 32'h140;
        drive(0, 1, 32'h140, 1, 32'h340, 1, 32'h300);
        #1;
        push("samecyc_old", S_TGT, 32'h300);
        drain();
        cyc();
        expect_pred("samecyc_new", 32'h140, 1, 1, 32'h340);

        // Flush beats a coincident allocate; stats still count.
        @(negedge clk);
        flush_btb = 1'b1;
        drive(1, 0, 32'h200, 1, 32'h400, 0, 32'h0);
        cyc();
        push("flush_br", S_BR, 32'd12);
        push("flush_mp", S_MP, 32'd8);
        drain();
        expect_pred("flush_new", 32'h200, 0, 0, 32'h204);
        expect_pred("flush_old", 32'h140, 0, 0, 32'h144);

        // Reset between edges with a resolve in flight.
        @(negedge clk);
        drive(1, 0, 32'h100, 1, 32'h200, 0, 32'h0);
        cyc();
        expect_pred("pre_rst", 32'h100, 1, 1, 32'h200);
        @(negedge clk);
        drive(1, 0, 32'h100, 0, 32'h200, 1, 32'h200);
        #2;
        rst_n = 1'b0;
        #1;
        push("midrst_hit", S_HIT, 32'd0);
        push("midrst_br", S_BR, 32'd0);
        push("midrst_mp", S_MP, 32'd0);
        drain();
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        push("postrst_br", S_BR, 32'd0);
        push("postrst_mp", S_MP, 32'd0);
        drain();
        expect_pred("postrst", 32'h100, 0, 0, 32'h104);

        // br_count saturation.
        @(negedge clk);
        force dut.r_br_count = 32'hFFFF_FFFF;
        drive(0, 1, 32'h100, 1, 32'h200, 1, 32'h200);
        @(posedge clk);
        @(negedge clk);
        release dut.r_br_count;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        push("sat_br", S_BR, 32'hFFFF_FFFF);
        push("sat_mp", S_MP, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
